// File: rtl/cybusm_pkg.sv
// Shared encodings for the CybusM-to-AHB-Lite bridge: AHB transfer codes,
// CybusM command codes, bridge state encoding and the default length limit.
package cybusm_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;

    // CybusM only defines INCR bursts; sizes above word are not supported.
    localparam logic [2:0] CBM_BURST_INCR = 3'd0;
    localparam logic [2:0] CBM_SIZE_MAX   = HSIZE_WORD;

    localparam int MAX_LEN_DEFAULT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RDOUT,
        ST_NEXT
    } state_t;

    // Byte distance between consecutive beats of the given transfer size.
    function automatic logic [31:0] beat_stride(input logic [2:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/cybusm_ahb_master_if.sv
// AHB-Lite signal bundle between the bridge (master) and the bus1 fabric.
interface cybusm_ahb_master_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/cybusm_ahb_addr_gen.sv
// Beat address register: loaded with the command start address, stepped by
// one beat stride after each successful beat. Wraps naturally modulo 2^32.
module cybusm_ahb_addr_gen
    import cybusm_pkg::*;
(
    input  logic        bus1_HCLK,
    input  logic        bus1_HRESETn,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic        inc,
    input  logic [2:0]  size,
    output logic [31:0] addr
);

    // Hold the current beat address; load on command accept, step on beat done.
    always_ff @(posedge bus1_HCLK or negedge bus1_HRESETn) begin
        if (!bus1_HRESETn) begin
            addr <= '0;
        end else if (load) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            addr <= load_addr;
        end else if (inc) begin
            addr <= addr + beat_stride(size);
        end
    end

endmodule

// File: rtl/cybusm_ahb_master.sv
// CybusM command bridge: executes each accepted command as a series of
// single NONSEQ/SINGLE AHB-Lite transfers, one beat at a time.
module cybusm_ahb_master
    import cybusm_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic        bus1_HCLK,
    input  logic        bus1_HRESETn,
    input  logic        cbm_read_req,
    input  logic        cbm_write_req,
    input  logic [2:0]  cbm_burst,
    input  logic [31:0] cbm_addr,
    input  logic [10:0] cbm_length,
    input  logic [2:0]  cbm_size,
    input  logic        cbm_lock,
    input  logic [31:0] cbm_write_data,
    output logic [31:0] cbm_read_data,
    output logic        cbm_command_busy,
    output logic        cbm_data_ready,
    output logic        cbm_error,
    output logic [10:0] cbm_count,
    cybusm_ahb_master_if.master ahb
);

    state_t      state_q, state_d;
    logic [10:0] length_q;
    logic [2:0]  size_q;
    logic        write_q;
    logic        lock_q;
    logic [31:0] hwdata_q;
    logic [31:0] addr_q;

    logic one_req, cmd_legal, accept, reject;
    logic beat_ok, beat_err, next_abort;
    logic [10:0] count_inc;

    assign one_req   = cbm_read_req ^ cbm_write_req;
    assign cmd_legal = (cbm_burst == CBM_BURST_INCR) && (cbm_size <= CBM_SIZE_MAX) &&
                       (cbm_length != 11'd0) && (cbm_length <= 11'(MAX_LEN));
    assign accept    = (state_q == ST_IDLE) && one_req && cmd_legal;
    assign reject    = (state_q == ST_IDLE) && (cbm_read_req || cbm_write_req) &&
                       !(one_req && cmd_legal);
    assign beat_ok    = (state_q == ST_DATA) && ahb.HREADY && !ahb.HRESP;
    assign beat_err   = (state_q == ST_DATA) && ahb.HREADY && ahb.HRESP;
    assign next_abort = (state_q == ST_NEXT) && cbm_read_req;
    assign count_inc  = cbm_count + 11'd1;

    cybusm_ahb_addr_gen u_addr_gen (
        .bus1_HCLK    (bus1_HCLK),
        .bus1_HRESETn (bus1_HRESETn),
        .load         (accept),
        .load_addr    (cbm_addr),
        .inc          (beat_ok),
        .size         (size_q),
        .addr         (addr_q)
    );

    // State register; async reset drops any transfer in flight.
    always_ff @(posedge bus1_HCLK or negedge bus1_HRESETn) begin
        if (!bus1_HRESETn) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // Next-state decode for the beat sequencer.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ADDR;
            ST_ADDR:  state_d = ST_DATA;
            ST_DATA: begin
                if (ahb.HREADY) begin
                    if (ahb.HRESP)                 state_d = ST_IDLE;
                    else if (!write_q)             state_d = ST_RDOUT;
                    else if (count_inc < length_q) state_d = ST_NEXT;
                    else                           state_d = ST_IDLE;
                end
            end
            ST_RDOUT: state_d = (cbm_count < length_q) ? ST_ADDR : ST_IDLE;
            ST_NEXT: begin
                if (cbm_read_req)       state_d = ST_IDLE;
                else if (cbm_write_req) state_d = ST_ADDR;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from state, so HREADY never reaches cbm_* combinationally.
    always_comb begin
        ahb.HTRANS       = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        ahb.HMASTLOCK    = lock_q && (state_q != ST_IDLE);
        cbm_command_busy = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RDOUT);
        cbm_data_ready   = (state_q == ST_IDLE) || (state_q == ST_NEXT) || (state_q == ST_RDOUT);
    end

    // Command latches, beat counter, write/read data registers and error pulse.
    always_ff @(posedge bus1_HCLK or negedge bus1_HRESETn) begin
        if (!bus1_HRESETn) begin
            length_q      <= '0;
            size_q        <= HSIZE_BYTE;
            write_q       <= 1'b0;
            lock_q        <= 1'b0;
            hwdata_q      <= '0;
            cbm_count     <= '0;
            cbm_read_data <= '0;
            cbm_error     <= 1'b0;
        end else begin
            cbm_error <= reject || beat_err || next_abort;
            if (accept) begin
                length_q  <= cbm_length;
                size_q    <= cbm_size;
                write_q   <= cbm_write_req;
                lock_q    <= cbm_lock;
                cbm_count <= '0;
                if (cbm_write_req) hwdata_q <= cbm_write_data;
            end
            if ((state_q == ST_NEXT) && cbm_write_req && !cbm_read_req) begin
                hwdata_q <= cbm_write_data;
            end
            if (beat_ok) begin
                cbm_count <= count_inc;
                if (!write_q) cbm_read_data <= ahb.HRDATA;
            end
        end
    end

    assign ahb.HADDR  = addr_q;
    assign ahb.HWRITE = write_q;
    assign ahb.HSIZE  = size_q;
    assign ahb.HBURST = HBURST_SINGLE;
    assign ahb.HWDATA = hwdata_q;

endmodule

// File: tb/tb_cybusm_ahb_master.sv
// Directed bench for cybusm_ahb_master: the bench plays the AHB slave and
// steps the CybusM requester cycle by cycle, checking against hand-derived values.
module tb_cybusm_ahb_master;

    logic        clk;
    logic        rst_n;
    logic        read_req, write_req, lock;
    logic [2:0]  burst, size;
    logic [31:0] addr, wdata;
    logic [10:0] length;
    logic [31:0] read_data;
    logic        busy, data_ready, error;
    logic [10:0] count;

    int checks = 0;
    int errors = 0;

    cybusm_ahb_master_if ahb_if ();

    cybusm_ahb_master dut (
        .bus1_HCLK        (clk),
        .bus1_HRESETn     (rst_n),
        .cbm_read_req     (read_req),
        .cbm_write_req    (write_req),
        .cbm_burst        (burst),
        .cbm_addr         (addr),
        .cbm_length       (length),
        .cbm_size         (size),
        .cbm_lock         (lock),
        .cbm_write_data   (wdata),
        .cbm_read_data    (read_data),
        .cbm_command_busy (busy),
        .cbm_data_ready   (data_ready),
        .cbm_error        (error),
        .cbm_count        (count),
        .ahb              (ahb_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge: outputs are stable, inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic rd, input logic wr, input logic [31:0] a, input logic [10:0] len,
                       input logic [2:0] sz, input logic lk, input logic [31:0] d);
        read_req  = rd;
        write_req = wr;
        addr      = a;
        length    = len;
        size      = sz;
        lock      = lk;
        wdata     = d;
    endtask

    task automatic idle_reqs();
        read_req  = 1'b0;
        write_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        read_req = 1'b0; write_req = 1'b0; lock = 1'b0;
        burst = 3'd0; size = 3'd0; addr = '0; wdata = '0; length = '0;
        ahb_if.HRDATA = '0; ahb_if.HREADY = 1'b1; ahb_if.HRESP = 1'b0;

        // Reset values
        step(); step();
        check("rst_htrans", ahb_if.HTRANS, 2'd0);
        check("rst_haddr", ahb_if.HADDR, 32'h0);
        check("rst_hwrite", ahb_if.HWRITE, 1'b0);
        check("rst_hsize", ahb_if.HSIZE, 3'd0);
        check("rst_hlock", ahb_if.HMASTLOCK, 1'b0);
        check("rst_hwdata", ahb_if.HWDATA, 32'h0);
        check("rst_rdata", read_data, 32'h0);
        check("rst_count", count, 11'd0);
        check("rst_error", error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", data_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // Single word write
        cmd(1'b0, 1'b1, 32'h1000FF00, 11'd1, 3'd2, 1'b0, 32'h000000A5);
        step(); idle_reqs();
        check("w1_htrans", ahb_if.HTRANS, 2'd2);
        check("w1_haddr", ahb_if.HADDR, 32'h1000FF00);
        check("w1_hwrite", ahb_if.HWRITE, 1'b1);
        check("w1_hsize", ahb_if.HSIZE, 3'd2);
        check("w1_hburst", ahb_if.HBURST, 3'd0);
        check("w1_busy_addr", busy, 1'b1);
        step();
        check("w1_hwdata", ahb_if.HWDATA, 32'h000000A5);
        check("w1_htrans_data", ahb_if.HTRANS, 2'd0);
        step();
        check("w1_count", count, 11'd1);
        check("w1_ready", data_ready, 1'b1);
        check("w1_busy", busy, 1'b0);

        // Four-beat halfword read with locked bus
        cmd(1'b1, 1'b0, 32'h00000100, 11'd4, 3'd1, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(); idle_reqs();
            check($sformatf("r4_htrans_%0d", i), ahb_if.HTRANS, 2'd2);
            check($sformatf("r4_haddr_%0d", i), ahb_if.HADDR, 32'h100 + 32'(2 * i));
            check($sformatf("r4_lock_%0d", i), ahb_if.HMASTLOCK, 1'b1);
            ahb_if.HRDATA = 32'h11 * 32'(i + 1);
            step();
            check($sformatf("r4_ready_data_%0d", i), data_ready, 1'b0);
            step();
            check($sformatf("r4_ready_%0d", i), data_ready, 1'b1);
            check($sformatf("r4_rdata_%0d", i), read_data, 32'h11 * 32'(i + 1));
            check($sformatf("r4_count_%0d", i), count, 11'(i + 1));
        end
        step();
        check("r4_final_count", count, 11'd4);
        check("r4_idle_busy", busy, 1'b0);
        check("r4_idle_lock", ahb_if.HMASTLOCK, 1'b0);

        // Two-beat write, three wait states on beat 1
        cmd(1'b0, 1'b1, 32'h00002000, 11'd2, 3'd2, 1'b0, 32'h11111111);
        step(); idle_reqs();
        check("ws_htrans", ahb_if.HTRANS, 2'd2);
        ahb_if.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ws_hold_busy_%0d", i), busy, 1'b1);
            check($sformatf("ws_hold_hwdata_%0d", i), ahb_if.HWDATA, 32'h11111111);
        end
        step();
        check("ws_last_data_count", count, 11'd0);
        check("ws_last_data_busy", busy, 1'b1);
        ahb_if.HREADY = 1'b1;
        step();
        check("ws_next_ready", data_ready, 1'b1);
        check("ws_next_busy", busy, 1'b0);
        check("ws_next_count", count, 11'd1);
        cmd(1'b0, 1'b1, 32'hDEAD0000, 11'd7, 3'd2, 1'b0, 32'h22222222);
        step(); idle_reqs();
        check("ws_b2_htrans", ahb_if.HTRANS, 2'd2);
        check("ws_b2_haddr", ahb_if.HADDR, 32'h00002004);
        check("ws_b2_hwdata", ahb_if.HWDATA, 32'h22222222);
        step();
        step();
        check("ws_final_count", count, 11'd2);
        check("ws_final_busy", busy, 1'b0);

        // ERROR response on beat 2 of a three-beat read
        cmd(1'b1, 1'b0, 32'h00000300, 11'd3, 3'd2, 1'b0, 32'h0);
        step(); idle_reqs();
        ahb_if.HRDATA = 32'h000000AA;
        step();
        step();
        check("er_rdata_b1", read_data, 32'h000000AA);
        step();
        check("er_haddr_b2", ahb_if.HADDR, 32'h00000304);
        ahb_if.HRESP = 1'b1;
        step();
        check("er_no_err_yet", error, 1'b0);
        step();
        ahb_if.HRESP = 1'b0;
        check("er_error_pulse", error, 1'b1);
        check("er_count", count, 11'd1);
        check("er_busy", busy, 1'b0);
        check("er_htrans", ahb_if.HTRANS, 2'd0);
        step();
        check("er_error_drop", error, 1'b0);
        check("er_no_nonseq", ahb_if.HTRANS, 2'd0);
        check("er_count_stable", count, 11'd1);

        // Illegal commands
        cmd(1'b0, 1'b1, 32'h0, 11'd1, 3'd3, 1'b0, 32'h0);
        step(); idle_reqs();
        check("ill_size_err", error, 1'b1);
        check("ill_size_htrans", ahb_if.HTRANS, 2'd0);
        step();
        check("ill_size_err_drop", error, 1'b0);
        cmd(1'b1, 1'b0, 32'h0, 11'd0, 3'd2, 1'b0, 32'h0);
        step(); idle_reqs();
        check("ill_len0_err", error, 1'b1);
        check("ill_len0_htrans", ahb_if.HTRANS, 2'd0);
        step();
        cmd(1'b1, 1'b1, 32'h0, 11'd1, 3'd2, 1'b0, 32'h0);
        step(); idle_reqs();
        check("ill_both_err", error, 1'b1);
        check("ill_both_htrans", ahb_if.HTRANS, 2'd0);
        step();
        cmd(1'b1, 1'b0, 32'h0, 11'd1025, 3'd2, 1'b0, 32'h0);
        step(); idle_reqs();
        check("ill_len_big_err", error, 1'b1);
        step();
        cmd(1'b1, 1'b0, 32'h0, 11'd1, 3'd2, 1'b0, 32'h0);
        burst = 3'd1;
        step(); idle_reqs(); burst = 3'd0;
        check("ill_burst_err", error, 1'b1);
        check("ill_burst_busy", busy, 1'b0);
        step();
        check("ill_count_stable", count, 11'd1);
        check("ill_htrans_final", ahb_if.HTRANS, 2'd0);

        // Address wrap, then reset during the data phase
        cmd(1'b0, 1'b1, 32'hFFFFFFFC, 11'd2, 3'd2, 1'b1, 32'h00000055);
        step(); idle_reqs();
        check("wr_haddr_b1", ahb_if.HADDR, 32'hFFFFFFFC);
        step();
        step();
        check("wr_next_ready", data_ready, 1'b1);
        cmd(1'b0, 1'b1, 32'h0, 11'd2, 3'd2, 1'b1, 32'h00000066);
        step(); idle_reqs();
        check("wr_haddr_wrap", ahb_if.HADDR, 32'h00000000);
        check("wr_htrans_b2", ahb_if.HTRANS, 2'd2);
        ahb_if.HREADY = 1'b0;
        step();
        check("wr_in_data_busy", busy, 1'b1);
        check("wr_in_data_lock", ahb_if.HMASTLOCK, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ar_htrans", ahb_if.HTRANS, 2'd0);
        check("ar_haddr", ahb_if.HADDR, 32'h0);
        check("ar_hwrite", ahb_if.HWRITE, 1'b0);
        check("ar_hsize", ahb_if.HSIZE, 3'd0);
        check("ar_hlock", ahb_if.HMASTLOCK, 1'b0);
        check("ar_hwdata", ahb_if.HWDATA, 32'h0);
        check("ar_busy", busy, 1'b0);
        check("ar_ready", data_ready, 1'b1);
        check("ar_count", count, 11'd0);
        check("ar_error", error, 1'b0);
        check("ar_rdata", read_data, 32'h0);
        ahb_if.HREADY = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("ar_post_error", error, 1'b0);
        check("ar_post_htrans", ahb_if.HTRANS, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
